// File: rtl/mulpoly_recombine.sv
// Rebuilds N = Q*D + R mod modu into an external read-modify-write N memory (MULPOLY_ZERO_SKIP_EN skips zero Q terms).
// Latency 2*(MAX_DEG+1) + 30*(degQ+1)*(degD+1) + 1 cycles start to recomb_done; start is ignored while busy.
// No backpressure: memories answer in exactly one cycle, one N write per cycle at most.
module mulpoly_recombine #(
  parameter int MAX_DEG  = 676,
  parameter int RED_BITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] modu,
  input  logic [10:0] degQ,
  input  logic [10:0] degD,
  output logic [10:0] mem_address_oQ,
  input  logic [12:0] mem_outputQ,
  output logic [10:0] mem_address_oD,
  input  logic [12:0] mem_outputD,
  output logic [10:0] mem_address_oR,
  input  logic [12:0] mem_outputR,
  output logic [10:0] mem_address_oN,
  input  logic [12:0] mem_outputN,
  output logic [10:0] mem_address_iN,
  output logic [12:0] mem_inputN,
  output logic        write_enableN,
  output logic [10:0] degN,
  output logic        busy,
  output logic        recomb_done,
  output logic        recomb_err
);

  localparam logic [10:0] LAST_K   = 11'(MAX_DEG);
  localparam logic [4:0]  LAST_RED = 5'(RED_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_RD, S_INIT_WR, S_QF, S_RD, S_WT, S_MUL, S_RED, S_WR, S_DONE
  } state_t;

`ifdef MULPOLY_ZERO_SKIP_EN
  localparam state_t MAC_ENTRY = S_QF;
`else
  localparam state_t MAC_ENTRY = S_RD;
`endif

  state_t state, stateNext;

  logic [11:0]         modR;
  logic [10:0]         degQr, degDr, k, i, j;
  logic [12:0]         opQ, opD, opN, rem;
  logic [RED_BITS-1:0] x;
  logic [4:0]          redCnt;
  logic [11:0]         degSum;
  logic [12:0]         remShift, remRed;
  logic                startBad, lastI, lastJ, zeroQ, advI;

  assign degSum   = {1'b0, degQ} + {1'b0, degD};
  assign startBad = (degSum > 12'(MAX_DEG)) || (modu < 12'd2);
  assign lastI    = (i == degQr);
  assign lastJ    = (j == degDr);
  // One restoring step: bring in the next dividend bit, subtract modu if it fits.
  assign remShift = {rem[11:0], x[RED_BITS-1]};
  assign remRed   = (remShift >= {1'b0, modR}) ? remShift - {1'b0, modR} : remShift;

`ifdef MULPOLY_ZERO_SKIP_EN
  // Q[i] was addressed in S_QF, so it is on the bus during the j=0 read cycle.
  assign zeroQ = (state == S_RD) && (j == '0) && (mem_outputQ == '0);
`else
  assign zeroQ = 1'b0;
`endif

  assign advI = ((state == S_RD) && zeroQ && !lastI) ||
                ((state == S_WR) && lastJ && !lastI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext      = state;
    recomb_done    = 1'b0;
    write_enableN  = 1'b0;
    mem_address_iN = '0;
    mem_inputN     = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (startBad) stateNext = S_DONE;
          else          stateNext = S_INIT_RD;
        end
      end
      S_INIT_RD: stateNext = S_INIT_WR;
      S_INIT_WR: begin
        write_enableN  = 1'b1;
        mem_address_iN = k;
        mem_inputN     = (k < degDr) ? mem_outputR : '0;
        if (k == LAST_K) stateNext = MAC_ENTRY;
        else             stateNext = S_INIT_RD;
      end
      S_QF: stateNext = S_RD;
      S_RD: begin
        if (zeroQ) begin
          if (lastI) stateNext = S_DONE;
          else       stateNext = S_QF;
        end else begin
          stateNext = S_WT;
        end
      end
      S_WT:  stateNext = S_MUL;
      S_MUL: stateNext = S_RED;
      S_RED: if (redCnt == LAST_RED) stateNext = S_WR;
      S_WR: begin
        write_enableN  = 1'b1;
        mem_address_iN = i + j;
        mem_inputN     = rem;
        if (!lastJ)     stateNext = S_RD;
        else if (lastI) stateNext = S_DONE;
        else            stateNext = MAC_ENTRY;
      end
      S_DONE: begin
        recomb_done = 1'b1;
        stateNext   = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
    busy = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modR           <= '0;
      degQr          <= '0;
      degDr          <= '0;
      k              <= '0;
      i              <= '0;
      j              <= '0;
      opQ            <= '0;
      opD            <= '0;
      opN            <= '0;
      rem            <= '0;
      x              <= '0;
      redCnt         <= '0;
      degN           <= '0;
      recomb_err     <= 1'b0;
      mem_address_oQ <= '0;
      mem_address_oD <= '0;
      mem_address_oR <= '0;
      mem_address_oN <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            modR       <= modu;
            degQr      <= degQ;
            degDr      <= degD;
            recomb_err <= startBad;
            degN       <= '0;
            k          <= '0;
            if (!startBad && degD != '0) mem_address_oR <= '0;
          end
        end
        S_INIT_WR: begin
          k <= k + 11'd1;
          if (k != LAST_K && (k + 11'd1) < degDr) mem_address_oR <= k + 11'd1;
          if (k == LAST_K) begin
            i              <= '0;
            j              <= '0;
            mem_address_oQ <= '0;
            mem_address_oD <= '0;
            mem_address_oN <= '0;
          end
        end
        S_WT: begin
          opQ <= mem_outputQ;
          opD <= mem_outputD;
          opN <= mem_outputN;
        end
        S_MUL: begin
          x      <= RED_BITS'(opN) + RED_BITS'(opQ) * RED_BITS'(opD);
          rem    <= '0;
          redCnt <= '0;
        end
        S_RED: begin
          rem    <= remRed;
          x      <= {x[RED_BITS-2:0], 1'b0};
          redCnt <= redCnt + 5'd1;
        end
        S_WR: begin
          if (!lastJ) begin
            j              <= j + 11'd1;
            mem_address_oD <= j + 11'd1;
            mem_address_oN <= i + j + 11'd1;
          end
        end
        default: ;
      endcase
      if (advI) begin
        i              <= i + 11'd1;
        j              <= '0;
        mem_address_oQ <= i + 11'd1;
        mem_address_oD <= '0;
        mem_address_oN <= i + 11'd1;
      end
      if (stateNext == S_DONE && state != S_IDLE) degN <= degQr + degDr;
    end
  end

endmodule

// File: tb/tb_mulpoly_recombine.sv
// Self-checking bench for mulpoly_recombine: behavioural memories, polynomial reference model, latency and protocol checks.
module tb_mulpoly_recombine;
  localparam int MAX_DEG = 676;
`ifdef MULPOLY_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] modu = '0;
  logic [10:0] degQ = '0, degD = '0;
  logic [10:0] aQ, aD, aR, aN, aIN, degN;
  logic [12:0] oQ, oD, oR, oN, inN;
  logic        wen, busy, recomb_done, recomb_err;

  logic [12:0] memQ [0:2047];
  logic [12:0] memD [0:2047];
  logic [12:0] memR [0:2047];
  logic [12:0] memN [0:2047];
  longint      expN [0:MAX_DEG];

  int tests = 0, fails = 0;
  int wrCount = 0, badWr = 0, lastWr = -1, curModu = 4096;

  always #5 clk = ~clk;

  mulpoly_recombine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modu(modu), .degQ(degQ), .degD(degD),
    .mem_address_oQ(aQ), .mem_outputQ(oQ), .mem_address_oD(aD), .mem_outputD(oD),
    .mem_address_oR(aR), .mem_outputR(oR), .mem_address_oN(aN), .mem_outputN(oN),
    .mem_address_iN(aIN), .mem_inputN(inN), .write_enableN(wen), .degN(degN),
    .busy(busy), .recomb_done(recomb_done), .recomb_err(recomb_err)
  );

  // Synchronous-read memories; N also records write statistics.
  always @(posedge clk) begin
    oQ <= memQ[aQ];
    oD <= memD[aD];
    oR <= memR[aR];
    oN <= memN[aN];
    if (wen) begin
      memN[aIN] <= inN;
      wrCount++;
      if (int'(inN) >= curModu) badWr++;
      lastWr = int'(aIN);
    end
  end

  function automatic int expLat(input int dq, input int dd);
    return 2 * (MAX_DEG + 1) + 30 * (dq + 1) * (dd + 1) + 1;
  endfunction

  // N[k] = (R[k] if k<degD) + sum over i+j=k of Q[i]*D[j], reduced once at the end.
  task automatic buildModel(input int m, input int dq, input int dd);
    for (int k = 0; k <= MAX_DEG; k++) expN[k] = (k < dd) ? longint'(memR[k]) : 0;
    for (int a = 0; a <= dq; a++)
      for (int b = 0; b <= dd; b++)
        expN[a + b] += longint'(memQ[a]) * longint'(memD[b]);
    for (int k = 0; k <= MAX_DEG; k++) expN[k] = expN[k] % longint'(m);
  endtask

  task automatic countBad(output int nb, output int firstK);
    nb = 0;
    firstK = -1;
    for (int k = 0; k <= MAX_DEG; k++)
      if (longint'(memN[k]) != expN[k]) begin
        if (firstK < 0) firstK = k;
        nb++;
      end
  endtask

  task automatic loadRandom(input int m);
    for (int k = 0; k <= MAX_DEG; k++) begin
      memQ[k] = 13'($urandom_range(m - 1, 0));
      memD[k] = 13'($urandom_range(m - 1, 0));
      memR[k] = 13'($urandom_range(m - 1, 0));
    end
  endtask

  task automatic runOp(input int m, input int dq, input int dd, input int bound,
                       output int cyc, output bit to, output logic busy1);
    @(negedge clk);
    modu = 12'(m);
    degQ = 11'(dq);
    degD = 11'(dd);
    curModu = m;
    start = 1'b1;
    cyc = 0;
    to = 1'b1;
    busy1 = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      start = 1'b0;
      cyc = c;
      if (c == 1) busy1 = busy;
      if (recomb_done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests++;
    if ({busy, recomb_done, recomb_err, wen} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000", {busy, recomb_done, recomb_err, wen});
    end
    tests++;
    if ({aQ, aD, aR, aN, aIN, inN, degN} !== '0) begin
      fails++;
      $display("FAIL reset_bus: got %h required 0", {aQ, aD, aR, aN, aIN, inN, degN});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, recomb_done, wen} !== 3'b000) begin
      fails++;
      $display("FAIL idle_quiet: got %b required 000", {busy, recomb_done, wen});
    end
  endtask

  task automatic loadT1;
    loadRandom(4091);
    memQ[0] = 13'd1; memQ[1] = 13'd1;
    memD[0] = 13'd2; memD[1] = 13'd1;
    memR[0] = 13'd3;
  endtask

  task automatic test_basic;
    int cyc, nb, fk, w0;
    bit to;
    logic b1;
    loadT1();
    buildModel(4091, 1, 1);
    w0 = wrCount;
    runOp(4091, 1, 1, 5000, cyc, to, b1);
    tests++;
    if (to) begin fails++; $display("FAIL t1_timeout: no recomb_done within 5000 cycles"); end
    tests++;
    if (SKIP ? (cyc > 1475 + 2) : (cyc != 1475)) begin
      fails++; $display("FAIL t1_latency: got %0d required 1475", cyc);
    end
    tests++;
    if ({b1, busy, recomb_err} !== 3'b100) begin
      fails++; $display("FAIL t1_busy_err: got %b required 100", {b1, busy, recomb_err});
    end
    tests++;
    if (degN !== 11'd2) begin fails++; $display("FAIL t1_degN: got %0d required 2", degN); end
    tests++;
    if ({memN[0], memN[1], memN[2], memN[3]} !== {13'd5, 13'd3, 13'd1, 13'd0}) begin
      fails++; $display("FAIL t1_coeffs: got %0d %0d %0d %0d required 5 3 1 0", memN[0], memN[1], memN[2], memN[3]);
    end
    countBad(nb, fk);
    tests++;
    if (nb != 0) begin
      fails++; $display("FAIL t1_ncontents: %0d wrong, first N[%0d]=%0d required %0d", nb, fk, memN[fk], expN[fk]);
    end
    tests++;
    if (wrCount - w0 != 681) begin
      fails++; $display("FAIL t1_writes: got %0d required 681", wrCount - w0);
    end
    @(negedge clk);
    tests++;
    if (recomb_done !== 1'b0) begin fails++; $display("FAIL t1_done_pulse: done still %b one cycle later", recomb_done); end
  endtask

  task automatic test_wrap;
    int cyc, nb, fk, bw0;
    bit to;
    logic b1;
    loadRandom(7);
    memQ[0] = 13'd6; memQ[1] = 13'd6;
    memD[0] = 13'd6; memD[1] = 13'd6;
    memR[0] = 13'd6;
    buildModel(7, 1, 1);
    bw0 = badWr;
    runOp(7, 1, 1, 5000, cyc, to, b1);
    tests++;
    if (to || (SKIP ? (cyc > expLat(1, 1) + 2) : (cyc != expLat(1, 1)))) begin
      fails++; $display("FAIL t2_latency: got %0d (timeout %0d) required %0d", cyc, to, expLat(1, 1));
    end
    countBad(nb, fk);
    tests++;
    if (nb != 0) begin
      fails++; $display("FAIL t2_ncontents: %0d wrong, first N[%0d]=%0d required %0d", nb, fk, memN[fk], expN[fk]);
    end
    tests++;
    if (badWr != bw0) begin fails++; $display("FAIL t2_range: %0d writes >= modu, required 0", badWr - bw0); end
  endtask

  task automatic test_error;
    int cyc, w0;
    bit to;
    logic b1;
    w0 = wrCount;
    runOp(4091, 400, 300, 20, cyc, to, b1);
    tests++;
    if (to || cyc != 1) begin fails++; $display("FAIL t3_done_at: got %0d (timeout %0d) required 1", cyc, to); end
    tests++;
    if ({recomb_err, b1} !== 2'b10) begin fails++; $display("FAIL t3_err_busy: got %b required 10", {recomb_err, b1}); end
    repeat (4) @(negedge clk);
    tests++;
    if ({recomb_err, recomb_done, busy} !== 3'b100) begin
      fails++; $display("FAIL t3_sticky: got %b required 100", {recomb_err, recomb_done, busy});
    end
    tests++;
    if (wrCount != w0) begin fails++; $display("FAIL t3_nowrite: got %0d writes required 0", wrCount - w0); end
    runOp(1, 1, 1, 20, cyc, to, b1);
    tests++;
    if (to || cyc != 1 || recomb_err !== 1'b1) begin
      fails++; $display("FAIL modu_low: done at %0d err %b required 1 and 1", cyc, recomb_err);
    end
  endtask

  task automatic test_abort;
    int cyc, nb, fk;
    bit to, sawDone;
    logic b1;
    loadT1();
    sawDone = 1'b0;
    @(negedge clk);
    modu = 12'd4091; degQ = 11'd1; degD = 11'd1; curModu = 4091;
    start = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      start = (c == 50);
      if (c == 50) begin degQ = 11'd400; degD = 11'd300; end
      if (recomb_done) sawDone = 1'b1;
      if (c == 60) begin
        tests++;
        if ({busy, recomb_err} !== 2'b10) begin
          fails++; $display("FAIL t4_restart_ignored: busy/err %b required 10", {busy, recomb_err});
        end
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, recomb_done, recomb_err, wen, aQ, aD, aR, aN, aIN, inN, degN} !== '0 || sawDone) begin
      fails++; $display("FAIL t4_abort: ctrl %b done_seen %0d required all 0",
                        {busy, recomb_done, recomb_err, wen}, sawDone);
    end
    @(negedge clk);
    rst_n = 1'b1;
    buildModel(4091, 1, 1);
    runOp(4091, 1, 1, 5000, cyc, to, b1);
    countBad(nb, fk);
    tests++;
    if (to || nb != 0 || recomb_err !== 1'b0 || (!SKIP && cyc != 1475)) begin
      fails++; $display("FAIL t4_rerun: cyc %0d timeout %0d bad %0d err %b required 1475 0 0 0", cyc, to, nb, recomb_err);
    end
  endtask

  task automatic test_random;
    int cyc, nb, fk, bw0, m, dq, dd;
    bit to;
    logic b1;
    for (int r = 0; r < 4; r++) begin
      m  = (r == 0) ? 2 : int'($urandom_range(4095, 3));
      dq = int'($urandom_range(5, 0));
      dd = int'($urandom_range(5, 0));
      loadRandom(m);
      buildModel(m, dq, dd);
      bw0 = badWr;
      runOp(m, dq, dd, 5000, cyc, to, b1);
      tests++;
      if (to || (SKIP ? (cyc > expLat(dq, dd) + dq + 1) : (cyc != expLat(dq, dd)))) begin
        fails++; $display("FAIL rnd%0d_latency: got %0d (timeout %0d) required %0d", r, cyc, to, expLat(dq, dd));
      end
      countBad(nb, fk);
      tests++;
      if (nb != 0 || badWr != bw0) begin
        fails++; $display("FAIL rnd%0d_ncontents: m=%0d dq=%0d dd=%0d %0d wrong first N[%0d]=%0d required %0d",
                          r, m, dq, dd, nb, fk, memN[fk], expN[fk]);
      end
      tests++;
      if (degN !== 11'(dq + dd)) begin fails++; $display("FAIL rnd%0d_degN: got %0d required %0d", r, degN, dq + dd); end
    end
  endtask

  task automatic test_degd_zero;
    int cyc, nb;
    bit to;
    logic b1;
    loadRandom(4091);
    memD[0] = 13'd1;
    memQ[MAX_DEG] = 13'(1 + $urandom_range(4089, 0));
    buildModel(4091, MAX_DEG, 0);
    runOp(4091, MAX_DEG, 0, 30000, cyc, to, b1);
    tests++;
    if (to || (SKIP ? (cyc > expLat(MAX_DEG, 0) + MAX_DEG + 1) : (cyc != expLat(MAX_DEG, 0)))) begin
      fails++; $display("FAIL t5_latency: got %0d (timeout %0d) required %0d", cyc, to, expLat(MAX_DEG, 0));
    end
    nb = 0;
    for (int k = 0; k <= MAX_DEG; k++) if (memN[k] !== memQ[k]) nb++;
    tests++;
    if (nb != 0) begin fails++; $display("FAIL t5_n_equals_q: %0d coefficients differ, required 0", nb); end
    tests++;
    if (lastWr != MAX_DEG) begin fails++; $display("FAIL t5_last_write: got %0d required %0d", lastWr, MAX_DEG); end
  endtask

`ifdef MULPOLY_ZERO_SKIP_EN
  task automatic test_zero_skip;
    int cyc, nb, fk, w0;
    bit to;
    logic b1;
    loadRandom(4091);
    memQ[0] = 13'd0; memQ[1] = 13'd0; memQ[2] = 13'd5;
    memD[0] = 13'd1; memD[1] = 13'd1;
    memR[0] = 13'd0;
    buildModel(4091, 2, 1);
    w0 = wrCount;
    runOp(4091, 2, 1, 5000, cyc, to, b1);
    countBad(nb, fk);
    tests++;
    if (to || nb != 0 || memN[2] !== 13'd5 || memN[3] !== 13'd5) begin
      fails++; $display("FAIL t6_ncontents: timeout %0d wrong %0d N2=%0d N3=%0d required 0 0 5 5", to, nb, memN[2], memN[3]);
    end
    tests++;
    if (cyc >= expLat(2, 1) - 60 || wrCount - w0 != 679) begin
      fails++; $display("FAIL t6_skip: latency %0d writes %0d required < %0d and 679", cyc, wrCount - w0, expLat(2, 1) - 60);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 2048; k++) begin
      memQ[k] = '0;
      memD[k] = '0;
      memR[k] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_error();
    test_abort();
    test_random();
    test_degd_zero();
`ifdef MULPOLY_ZERO_SKIP_EN
    test_zero_skip();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
